// File: rtl/fifo_block_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_block_pkg
// Shared types and constants for the LDPC input FIFO block reader.
//   state_t      : reader FSM state (FILL collects words, OUT offers the block)
//   block_width  : width of one packed block from word width and word count
//   READ_LATENCY : cycles from fifo_r_en to valid fifo_data (fixed FIFO property)
// -----------------------------------------------------------------------------
package fifo_block_pkg;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    // The capture path is built around a single rd_pending flop, so the FIFO
    // must present data exactly one cycle after the read enable.
    localparam int READ_LATENCY = 1;

    function automatic int block_width(input int word_w, input int words);
        return word_w * words;
    endfunction

endpackage

// File: rtl/fifo_block_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_block_reader_if
// Bundles the FIFO read side and the block handshake of the reader.
//   fifo_empty / fifo_r_en / fifo_data : FIFO read port (data one cycle after r_en)
//   blk_data / blk_valid / blk_ready    : packed block to the encoder core
//   busy / blk_cnt                      : partial-block flag, delivered-block count
// Modports:
//   master : the reader itself
//   slave  : the environment (FIFO + encoder core)
// -----------------------------------------------------------------------------
interface fifo_block_reader_if
    import fifo_block_pkg::*;
#(
    parameter int FIFO_data_size  = 3,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CNT_W           = 16
);

    localparam int BLOCK_W = block_width(FIFO_data_size, WORDS_PER_BLOCK);

    logic                      fifo_empty;
    logic                      fifo_r_en;
    logic [FIFO_data_size-1:0] fifo_data;
    logic [BLOCK_W-1:0]        blk_data;
    logic                      blk_valid;
    logic                      blk_ready;
    logic                      busy;
    logic [CNT_W-1:0]          blk_cnt;

    modport master (
        input  fifo_empty, fifo_data, blk_ready,
        output fifo_r_en, blk_data, blk_valid, busy, blk_cnt
    );

    modport slave (
        output fifo_empty, fifo_data, blk_ready,
        input  fifo_r_en, blk_data, blk_valid, busy, blk_cnt
    );

endinterface

// File: rtl/fifo_block_reader_packer.sv
// -----------------------------------------------------------------------------
// block_packer
// Indexed capture register: each write drops din into slice idx of dout and
// advances idx. No shifting, so earlier words never move once captured.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart at word 0 (register contents are kept until overwritten)
//   wr       : capture din into slice idx
//   idx      : number of words captured so far in the current block
//   din      : one FIFO word
//   dout     : packed block, word 0 in the LSBs
// -----------------------------------------------------------------------------
module block_packer #(
    parameter int W     = 3,
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    output logic [IDX_W-1:0] idx,
    input  logic [W-1:0]     din,
    output logic [W*N-1:0]   dout
);

    // NOTE: the block register is reset along with the index so blk_data reads
    // zero out of reset; a pure data store could skip the reset term.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            dout <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (wr) begin
            dout[idx*W +: W] <= din;
            idx              <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_block_reader.sv
// -----------------------------------------------------------------------------
// fifo_block_reader
// Pops words from the LDPC input FIFO whenever it is non-empty, packs
// WORDS_PER_BLOCK of them into one block and offers it over valid/ready.
// One block in flight at a time; reads stop while a block waits in OUT.
//   clk  : FIFO read / encoder clock
//   rst  : asynchronous active-low reset
//   bus  : fifo_block_reader_if.master (FIFO read port, block handshake,
//          busy flag, delivered-block counter)
// -----------------------------------------------------------------------------
module fifo_block_reader
    import fifo_block_pkg::*;
#(
    parameter int FIFO_data_size  = 3,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_block_reader_if.master      bus
);

    localparam int BLOCK_W = block_width(FIFO_data_size, WORDS_PER_BLOCK);
    localparam int IDX_W   = $clog2(WORDS_PER_BLOCK + 1);

    state_t             state, state_next;
    logic [IDX_W-1:0]   issued;      // reads requested for this block
    logic [IDX_W-1:0]   recvd;       // words captured for this block
    logic               rd_pending;  // a read issued last cycle returns data now
    logic               rd_en;
    logic               xfer;
    logic               last_capture;
    logic [CNT_W-1:0]   blk_cnt;
    logic [BLOCK_W-1:0] blk_data;

    assign last_capture = rd_pending && (recvd == IDX_W'(WORDS_PER_BLOCK - 1));
    assign xfer         = (state == OUT) && bus.blk_ready;

    // NOTE: every output of this always_comb gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        case (state)
            FILL: begin
                // rst is in the term so the enable is low during reset even
                // though this path is purely combinational.
                rd_en = !bus.fifo_empty
                        && (issued < IDX_W'(WORDS_PER_BLOCK))
                        && rst;
                if (last_capture) state_next = OUT;
            end
            OUT: begin
                if (bus.blk_ready) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            issued     <= '0;
            rd_pending <= 1'b0;
            blk_cnt    <= '0;
        end else begin
            state      <= state_next;
            rd_pending <= rd_en;
            if (xfer) begin
                issued  <= '0;
                blk_cnt <= blk_cnt + 1'b1;
            end else if (rd_en) begin
                // rd_en already requires issued < WORDS_PER_BLOCK, which
                // makes this counter saturate at one full block.
                issued <= issued + 1'b1;
            end
        end
    end

    block_packer #(
        .W     (FIFO_data_size),
        .N     (WORDS_PER_BLOCK),
        .IDX_W (IDX_W)
    ) u_packer (
        .clk  (clk),
        .rst  (rst),
        .clr  (xfer),
        .wr   (rd_pending),
        .idx  (recvd),
        .din  (bus.fifo_data),
        .dout (blk_data)
    );

    assign bus.fifo_r_en = rd_en;
    assign bus.blk_data  = blk_data;
    assign bus.blk_valid = (state == OUT);
    assign bus.busy      = (state == FILL) && (recvd != '0);
    assign bus.blk_cnt   = blk_cnt;

endmodule

// File: tb/tb_fifo_block_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_block_reader
// Directed bench for fifo_block_reader with 3-bit words, 4 words per block and
// a 4-bit block counter. A queue stands in for the FIFO: a read enable seen
// before an edge returns the next queued word just after that edge.
// Outputs are sampled on the falling edge; inputs change just after the rising
// edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_block_reader;

    localparam int FDS   = 3;
    localparam int WPB   = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fifo_block_reader_if #(
        .FIFO_data_size  (FDS),
        .WORDS_PER_BLOCK (WPB),
        .CNT_W           (CNT_W)
    ) bus ();

    fifo_block_reader #(
        .FIFO_data_size  (FDS),
        .WORDS_PER_BLOCK (WPB),
        .CNT_W           (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [FDS-1:0] q[$];
    bit             gap_mode = 1'b0;
    int             gap_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_empty();
        bus.fifo_empty = (q.size() == 0) || (gap_left > 0);
    endtask

    task automatic push4(input logic [FDS-1:0] w0, input logic [FDS-1:0] w1,
                         input logic [FDS-1:0] w2, input logic [FDS-1:0] w3);
        q.push_back(w0);
        q.push_back(w1);
        q.push_back(w2);
        q.push_back(w3);
        update_empty();
    endtask

    // One clock cycle: called on a falling edge, returns on the next one.
    task automatic step();
        logic ren;
        ren = bus.fifo_r_en;
        @(posedge clk);
        #1;
        if (ren && q.size() > 0) begin
            bus.fifo_data = q.pop_front();
            gap_left      = gap_mode ? 3 : 0;
        end else if (gap_left > 0) begin
            gap_left--;
        end
        update_empty();
        @(negedge clk);
    endtask

    // Steps until blk_valid is seen, then one more cycle (the transfer edge
    // when ready is high). Bounded so a stuck DUT still reaches the summary.
    task automatic run_block(output logic [31:0] data, output bit ok);
        ok   = 1'b0;
        data = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.blk_valid) begin
                ok   = 1'b1;
                data = 32'(bus.blk_data);
            end
            step();
        end
    endtask

    initial begin
        logic [31:0] data;
        logic [31:0] d0;
        bit          ok;
        logic [7:0]  ren_bits, val_bits, busy_bits;
        int          viol, nren, bad_valid, bad_data, hold_ren;

        bus.fifo_data  = '0;
        bus.blk_ready  = 1'b1;
        push4(3'd1, 3'd2, 3'd3, 3'd4);

        // ---------------- reset held with FIFO non-empty and ready high
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_r_en",  32'(bus.fifo_r_en), 32'd0);
            check("rst_valid", 32'(bus.blk_valid), 32'd0);
            check("rst_data",  32'(bus.blk_data),  32'd0);
            check("rst_cnt",   32'(bus.blk_cnt),   32'd0);
            check("rst_busy",  32'(bus.busy),      32'd0);
            step();
        end

        // ---------------- basic block 1,2,3,4
        rst = 1'b1;
        #1;
        ren_bits  = '0;
        val_bits  = '0;
        busy_bits = '0;
        data      = '0;
        for (int i = 0; i < 8; i++) begin
            ren_bits[i]  = bus.fifo_r_en;
            val_bits[i]  = bus.blk_valid;
            busy_bits[i] = bus.busy;
            if (bus.blk_valid) data = 32'(bus.blk_data);
            step();
        end
        check("basic_r_en_trace",  32'(ren_bits),  32'h0F);
        check("basic_valid_trace", 32'(val_bits),  32'h20);
        check("basic_busy_trace",  32'(busy_bits), 32'h1C);
        check("basic_data",        data,           32'h8D1);
        check("basic_cnt",         32'(bus.blk_cnt), 32'd1);

        // ---------------- empty gaps: 5,6,7,0 with 3 empty cycles between words
        gap_mode = 1'b1;
        push4(3'd5, 3'd6, 3'd7, 3'd0);
        #1;
        ok   = 1'b0;
        viol = 0;
        nren = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (bus.fifo_r_en && bus.fifo_empty) viol++;
            if (bus.fifo_r_en) nren++;
            if (bus.blk_valid) begin
                ok   = 1'b1;
                data = 32'(bus.blk_data);
            end
            step();
        end
        gap_mode = 1'b0;
        gap_left = 0;
        update_empty();
        check("gap_block_seen",    32'(ok),   32'd1);
        check("gap_r_en_on_empty", 32'(viol), 32'd0);
        check("gap_read_count",    32'(nren), 32'd4);
        check("gap_data",          data,      32'h1F5);
        check("gap_cnt",           32'(bus.blk_cnt), 32'd2);

        // ---------------- backpressure: ready low for 10 cycles, FIFO non-empty
        bus.blk_ready = 1'b0;
        push4(3'd1, 3'd2, 3'd3, 3'd4);
        push4(3'd2, 3'd2, 3'd2, 3'd2);
        #1;
        run_block(d0, ok);
        check("bp_block_seen", 32'(ok), 32'd1);
        check("bp_data",       d0,      32'h8D1);
        bad_valid = 0;
        bad_data  = 0;
        hold_ren  = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.blk_valid !== 1'b1) bad_valid++;
            if (32'(bus.blk_data) !== d0) bad_data++;
            if (bus.fifo_r_en !== 1'b0) hold_ren++;
            step();
        end
        check("bp_valid_held", 32'(bad_valid), 32'd0);
        check("bp_data_held",  32'(bad_data),  32'd0);
        check("bp_no_reads",   32'(hold_ren),  32'd0);
        bus.blk_ready = 1'b1;
        #1;
        check("bp_valid_at_ready", 32'(bus.blk_valid), 32'd1);
        step();
        check("bp_valid_dropped", 32'(bus.blk_valid), 32'd0);
        check("bp_r_en_resumed",  32'(bus.fifo_r_en), 32'd1);
        check("bp_cnt",           32'(bus.blk_cnt),   32'd3);
        run_block(data, ok);
        check("bp_next_seen", 32'(ok), 32'd1);
        check("bp_next_data", data,     32'h492);
        check("bp_next_cnt",  32'(bus.blk_cnt), 32'd4);

        // ---------------- reset mid-block after two captured words
        push4(3'd7, 3'd7, 3'd7, 3'd7);
        #1;
        step();
        step();
        step();
        check("mid_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_busy_in_rst",  32'(bus.busy),      32'd0);
        check("mid_cnt_in_rst",   32'(bus.blk_cnt),   32'd0);
        check("mid_r_en_in_rst",  32'(bus.fifo_r_en), 32'd0);
        check("mid_data_in_rst",  32'(bus.blk_data),  32'd0);
        q.delete();
        update_empty();
        step();
        push4(3'd1, 3'd2, 3'd3, 3'd4);
        rst = 1'b1;
        #1;
        run_block(data, ok);
        check("mid_block_seen", 32'(ok), 32'd1);
        check("mid_data",       data,     32'h8D1);
        check("mid_cnt",        32'(bus.blk_cnt), 32'd1);

        // ---------------- counter wrap with a 4-bit counter
        rst = 1'b0;
        #1;
        step();
        rst = 1'b1;
        #1;
        check("wrap_cnt_start", 32'(bus.blk_cnt), 32'd0);
        for (int b = 1; b <= 17; b++) begin
            push4(3'(b), 3'(b + 1), 3'(b + 2), 3'(b + 3));
            #1;
            run_block(data, ok);
            if (!ok) check("wrap_block_seen", 32'(ok), 32'd1);
            if (b == 15) check("wrap_cnt_15", 32'(bus.blk_cnt), 32'd15);
            if (b == 16) check("wrap_cnt_16", 32'(bus.blk_cnt), 32'd0);
            if (b == 17) begin
                check("wrap_cnt_17",  32'(bus.blk_cnt), 32'd1);
                check("wrap_data_17", data,             32'h8D1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_block_reader.md
Name: fifo_block_reader

Overview:
- Consumer for the read side of the LDPC input FIFO. Pops FIFO_data_size-bit words whenever the FIFO is non-empty.
- Packs WORDS_PER_BLOCK consecutive words into one block and presents it to the LDPC encoder core over a valid/ready handshake.
- Lives in the encoder clock domain, i.e. the FIFO read clock. Single clock.

Parameters:
- FIFO_data_size, 3: width of one FIFO word.
- WORDS_PER_BLOCK, 8: words per output block, >= 2.
- CNT_W, 16: width of the delivered-block counter.
- Derived (localparam): BLOCK_W = FIFO_data_size*WORDS_PER_BLOCK; IDX_W = $clog2(WORDS_PER_BLOCK+1).

Ports:
- clk  in  1  block clock (FIFO read clock)
- rst  in  1  reset, asynchronous, active-low
- fifo_empty  in  1  FIFO empty flag
- fifo_r_en  out  1  FIFO read enable
- fifo_data  in  FIFO_data_size  FIFO read data; valid the cycle after fifo_r_en
- blk_data  out  BLOCK_W  packed block; word 0 in LSBs
- blk_valid  out  1  block available
- blk_ready  in  1  encoder accepts block
- busy  out  1  partial block held (received count > 0, state FILL)
- blk_cnt  out  CNT_W  blocks delivered, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, async):
  - state = FILL; issued, recvd, rd_pending = 0.
  - blk_data = 0, blk_valid = 0, blk_cnt = 0, busy = 0, fifo_r_en = 0.
- States: FILL, OUT.
- fifo_r_en (combinational):
  - fifo_r_en = (state==FILL) && !fifo_empty && (issued < WORDS_PER_BLOCK) && rst.
  - Never asserted while fifo_empty=1. Never asserted in OUT.
- FIFO read latency is fixed at 1:
  - rd_pending <= fifo_r_en.
  - When rd_pending=1, fifo_data is captured into slice recvd of the block register, and recvd increments.
- issued increments on every cycle with fifo_r_en=1. It saturates at WORDS_PER_BLOCK, so the block never over-reads.
- FILL -> OUT: on the edge capturing word WORDS_PER_BLOCK-1.
  - blk_valid rises the next cycle, i.e. 2 cycles after the last fifo_r_en.
- In OUT:
  - blk_valid=1; blk_data held stable.
  - Transfer occurs on the edge where blk_valid && blk_ready.
  - On transfer: state -> FILL, issued/recvd -> 0, blk_cnt += 1 (wraps), blk_valid -> 0 the next cycle.
  - blk_data keeps its old value until overwritten by captures.
- blk_ready is ignored outside OUT. A ready already high on OUT entry gives a 1-cycle blk_valid pulse.
- Word ordering: word k occupies blk_data[k*FIFO_data_size +: FIFO_data_size].
- Empty gaps: fifo_empty toggling mid-block only stalls. Words stay contiguous and in order; no bubbles appear in blk_data.
- Reset mid-block: the partial block is discarded. The next block starts at word 0 and blk_cnt returns to 0.
- No throughput overlap: at most one block in flight. Minimum block period is WORDS_PER_BLOCK+2 cycles with ready held high.

Decomposition:
- Package fifo_block_pkg:
  - state enum (FILL, OUT), typedef state_t;
  - function for BLOCK_W;
  - constant READ_LATENCY = 1.
- Sub-module block_packer: shift-free indexed capture register plus recvd counter, with ports clk, rst, clr, wr, idx, din, dout.
- The FSM and the issued/blk_cnt counters stay in the top.

Test Plan:
- Reset check: hold rst=0 with fifo_empty=0 and blk_ready=1 -> fifo_r_en=0, blk_valid=0, blk_data=0, blk_cnt=0 throughout.
- Basic block, WORDS_PER_BLOCK=4, FIFO_data_size=3: FIFO supplies 1,2,3,4 with fifo_empty=0 and blk_ready=1.
  - fifo_r_en high for exactly 4 consecutive cycles t..t+3.
  - blk_valid=1 in cycle t+5 only, with blk_data=12'h8D1.
  - blk_cnt=1 afterwards.
- Empty gaps: words 5,6,7,0 with fifo_empty=1 for 3 cycles between words -> fifo_r_en never high while empty; blk_data=12'h1F5 ({0,7,6,5}).
- Backpressure: blk_ready=0 for 10 cycles after blk_valid rises, FIFO non-empty.
  - blk_valid stays 1 with blk_data stable; fifo_r_en=0 all 10 cycles.
  - Transfer happens on the first ready cycle; fifo_r_en resumes the following cycle.
- Reset mid-block: assert rst=0 after 2 words are captured, then release and supply 1,2,3,4.
  - busy drops immediately; output block = 12'h8D1; the stale words do not appear.
- Counter wrap, CNT_W=4: deliver 17 blocks -> blk_cnt reads 15 after block 15, 0 after block 16, 1 after block 17.
